// File: rtl/spi_slave_shifter.sv
// rtl/spi_slave_shifter.sv - SPI slave serial engine: pin synchronizers, CPOL/CPHA shifter, RX/TX byte buffers
// Optional feature macro: SPI_SLAVE_LSBFE_EN (adds lsbfe_i for LSB-first frames)
module spi_slave_shifter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       PCLK,
    input  logic       PRESET_n,
    input  logic       spe_i,
    input  logic       cpol_i,
    input  logic       cpha_i,
`ifdef SPI_SLAVE_LSBFE_EN
    input  logic       lsbfe_i,
`endif
    input  logic       sclk_i,
    input  logic       ss_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_load_i,
    output logic       tx_empty_o,
    output logic [7:0] rx_data_o,
    output logic       rx_full_o,
    input  logic       rx_ack_i,
    output logic       overrun_o,
    input  logic       overrun_clr_i,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic sclk_hist, ss_hist;
    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, drive_edge;
    logic ss_fall;

    logic       lsb_first;
    logic       frame_start, run;
    logic       sample_ev, drive_ev, frame_done_ev;
    logic       reload, shift_drive, consume;

    logic [7:0] rx_shift, rx_next;
    logic [2:0] bit_cnt;
    logic       armed;          // a sample has happened since the last drive edge
    logic       frame_pending;  // 8th sample seen, CPHA=0 reload waits for the trailing edge

    logic [7:0] tx_shift, tx_buf, tx_hold, tx_pick, load_val, present_src;
    logic       out_bit;
    logic       primed;         // tx_hold carries a byte reloaded at the end of the last frame

`ifdef SPI_SLAVE_LSBFE_EN
    assign lsb_first = lsbfe_i;
`else
    assign lsb_first = 1'b0;
`endif

    // Bit presented first on the wire for a given byte, and the byte left after presenting it
    function automatic logic first_bit(input logic [7:0] v, input logic lsb);
        return lsb ? v[0] : v[7];
    endfunction

    function automatic logic [7:0] after_bit(input logic [7:0] v, input logic lsb);
        return lsb ? {1'b1, v[7:1]} : {v[6:0], 1'b1};
    endfunction

    // Pin synchronizers plus history flops used for edge detection
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_hist <= 1'b0;
            ss_hist   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            ss_hist   <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign ss_s        = ss_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_hist;
    assign sclk_fall   = ~sclk_s & sclk_hist;
    assign ss_fall     = ~ss_s & ss_hist;
    assign lead_edge   = cpol_i ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_i ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_i ? trail_edge : lead_edge;
    assign drive_edge  = cpha_i ? lead_edge : trail_edge;

    // FSM state register
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and frame control strobes
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        run         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (spe_i && ss_fall) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                frame_start = spe_i;
                state_d     = spe_i ? ST_ACTIVE : ST_IDLE;
            end
            ST_ACTIVE: begin
                if (!spe_i || ss_s) begin
                    state_d = ST_IDLE;
                end else begin
                    run = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sample_ev     = run & sample_edge;
    assign drive_ev      = run & drive_edge;
    assign frame_done_ev = sample_ev & (bit_cnt == 3'd7);
    assign reload        = cpha_i ? frame_done_ev : (drive_ev & armed & frame_pending);
    assign shift_drive   = drive_ev & (cpha_i | (armed & ~frame_pending));
    assign tx_pick       = tx_empty_o ? 8'hFF : tx_buf;
    assign load_val      = primed ? tx_hold : tx_pick;
    assign present_src   = frame_start ? load_val : tx_pick;
    assign consume       = (frame_start & ~primed) | reload;
    assign rx_next       = lsb_first ? {mosi_s, rx_shift[7:1]} : {rx_shift[6:0], mosi_s};

    // RX shift register, bit counter and sample/drive sequencing flags
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            rx_shift      <= 8'h00;
            bit_cnt       <= 3'd0;
            armed         <= 1'b0;
            frame_pending <= 1'b0;
        end else if (!spe_i) begin
            rx_shift      <= 8'h00;
            bit_cnt       <= 3'd0;
            armed         <= 1'b0;
            frame_pending <= 1'b0;
        end else if (!run) begin
            bit_cnt       <= 3'd0;
            armed         <= 1'b0;
            frame_pending <= 1'b0;
        end else if (sample_ev) begin
            rx_shift <= rx_next;
            armed    <= 1'b1;
            if (bit_cnt == 3'd7) begin
                bit_cnt       <= 3'd0;
                frame_pending <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end else if (drive_ev) begin
            armed         <= 1'b0;
            frame_pending <= 1'b0;
        end
    end

    // TX shifter: CPHA=0 presents the first bit at load time, CPHA=1 waits for the first leading edge
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            tx_shift <= 8'h00;
            out_bit  <= 1'b0;
        end else if (!spe_i) begin
            tx_shift <= 8'h00;
            out_bit  <= 1'b0;
        end else if (frame_start || reload) begin
            if (cpha_i) begin
                tx_shift <= present_src;
            end else begin
                out_bit  <= first_bit(present_src, lsb_first);
                tx_shift <= after_bit(present_src, lsb_first);
            end
        end else if (shift_drive) begin
            out_bit  <= first_bit(tx_shift, lsb_first);
            tx_shift <= after_bit(tx_shift, lsb_first);
        end
    end

    // TX buffer; a reload that is not followed by more bits keeps its byte for the next frame
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            tx_buf     <= 8'h00;
            tx_empty_o <= 1'b1;
            tx_hold    <= 8'h00;
            primed     <= 1'b0;
        end else begin
            if (consume) begin
                tx_empty_o <= 1'b1;
            end
            if (tx_load_i && tx_empty_o) begin
                tx_buf     <= tx_data_i;
                tx_empty_o <= 1'b0;
            end
            if (frame_start) begin
                primed <= 1'b0;
            end else if (reload) begin
                primed  <= ~tx_empty_o;
                tx_hold <= tx_pick;
            end else if (sample_ev || drive_ev) begin
                primed <= 1'b0;
            end
        end
    end

    // RX buffer, full flag and sticky overrun; a same-cycle ack makes room for the new byte
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            rx_data_o <= 8'h00;
            rx_full_o <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (frame_done_ev && (!rx_full_o || rx_ack_i)) begin
                rx_data_o <= rx_next;
                rx_full_o <= 1'b1;
            end else if (rx_ack_i) begin
                rx_full_o <= 1'b0;
            end
            if (frame_done_ev && rx_full_o && !rx_ack_i) begin
                overrun_o <= 1'b1;
            end else if (overrun_clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    // Registered pin-side outputs
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            miso_o    <= 1'b0;
            miso_oe_o <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            miso_o    <= (state_q != ST_IDLE) ? out_bit : 1'b0;
            miso_oe_o <= (state_d == ST_ACTIVE);
            busy_o    <= (state_d == ST_ACTIVE);
        end
    end

endmodule

// File: doc/spi_slave_shifter.md
# spi_slave_shifter

SPI slave-side serial engine: the responder for the SPI master clock/flag generator. It oversamples an external SCLK, SS_n and MOSI in the PCLK domain and shifts 8-bit frames in on MOSI and out on MISO in all four CPOL/CPHA modes. It presents parallel RX/TX byte buffers to the APB register block.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on sclk_i, ss_n_i and mosi_i; legal values are 2 or 3.

Ports (reset PRESET_n, asynchronous, active-low; clock PCLK):
- PCLK  in  1  system clock
- PRESET_n  in  1  asynchronous active-low reset
- spe_i  in  1  slave enable; when low the block is forced to IDLE and both shift registers clear
- cpol_i, cpha_i  in  1 each  SPI mode; static while ss_n_i is low
- sclk_i, ss_n_i, mosi_i  in  1 each  SPI pins, asynchronous to PCLK
- miso_o  out  1  serial data out
- miso_oe_o  out  1  MISO tristate enable, high only in ACTIVE
- tx_data_i  in  8  byte to transmit
- tx_load_i  in  1  write strobe for the TX buffer; accepted only when tx_empty_o=1
- tx_empty_o  out  1  TX buffer free
- rx_data_o  out  8  last received byte
- rx_full_o  out  1  rx_data_o holds an unread byte
- rx_ack_i  in  1  clears rx_full_o
- overrun_o  out  1  sticky; a frame completed while rx_full_o=1
- overrun_clr_i  in  1  clears overrun_o
- busy_o  out  1  high in ACTIVE

## Operation
- Synchronize the three pins with SYNC_STAGES flops, plus one history flop on SCLK for edge detection.
- Leading edge is the SCLK edge leaving the CPOL idle level; trailing edge is the other edge.
- The sample edge is the leading edge when CPHA=0 and the trailing edge when CPHA=1. The drive edge is the opposite edge.
- FSM states:
  - IDLE: miso_oe_o=0, bit count 0.
    - IDLE -> LOAD when synchronized ss_n falls and spe_i=1.
  - LOAD (one cycle): frame start.
    - tx_shift <= buffer if tx_empty_o=0, else 8'hFF.
    - Set tx_empty_o=1.
    - If CPHA=0, miso_o <= tx_shift bit 7 (the first bit is valid before the first leading edge).
    - LOAD -> ACTIVE.
  - ACTIVE:
    - On each sample edge: rx_shift <= {rx_shift[6:0], mosi}, bit count +1.
    - On each drive edge, with CPHA=0 only after at least one sample: miso_o <= next tx bit.
    - After the 8th sample, the frame completes:
      - If rx_full_o=0: rx_data_o <= assembled byte, rx_full_o <= 1.
      - Else: rx_data_o is unchanged and overrun_o <= 1.
    - Frame completes with ss_n still low: CPHA=0 reloads tx_shift on the following trailing edge; CPHA=1 reloads it immediately. Bit count returns to 0.
    - ACTIVE -> IDLE on synchronized ss_n rising or spe_i=0.
- Boundary conditions:
  - ss_n rises mid-frame: the partial byte is discarded, nothing changes on the RX side, and the count resets.
  - rx_ack_i and frame completion in the same cycle: rx_data_o takes the new byte, rx_full_o stays 1, no overrun.
  - tx_load_i when tx_empty_o=0: ignored.
  - tx_load_i in the LOAD cycle with the buffer empty: this frame sends 8'hFF, and the loaded byte is held for the next frame.
  - overrun_clr_i and a new overrun in the same cycle: overrun_o is set.
- Reset values: miso_o=0, miso_oe_o=0, tx_empty_o=1, rx_data_o=8'h00, rx_full_o=0, overrun_o=0, busy_o=0, FSM in IDLE.

## Timing
- Pin-to-internal-event latency is SYNC_STAGES+1 PCLK cycles.
- The SCLK half-period must be at least SYNC_STAGES+3 PCLK cycles. Faster SCLK is unsupported and its behaviour is undefined.
- MISO changes SYNC_STAGES+2 PCLK cycles after the drive edge at the pin.
- rx_full_o rises 1 cycle after the internal 8th sample edge.
- tx_empty_o rises the cycle after LOAD or reload.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- SPI_SLAVE_LSBFE_EN defined:
  - Adds input lsbfe_i (1 bit).
  - When lsbfe_i=1, TX shifts out bit 0 first and RX assembles as {mosi, rx_shift[7:1]}.
- SPI_SLAVE_LSBFE_EN undefined: the port is absent and frames are always MSB first.

## Test plan
- Mode 0, PCLK:SCLK ratio 8, tx 8'hA5 preloaded, master sends 8'h3C -> MISO carries A5 MSB first, rx_data_o=8'h3C, rx_full_o=1, tx_empty_o=1.
- Modes 1, 2 and 3, each sending 8'hC3 both ways -> byte received correctly in every mode, MISO stable around every master sample edge.
- Two back-to-back frames without ack, sending 8'h11 then 8'h22 -> rx_data_o=8'h11, overrun_o=1. overrun_clr_i clears it. An ack in the same cycle as frame completion gives rx_data_o=8'h22 and no overrun.
- TX buffer empty at frame start -> MISO sends 8'hFF. tx_load_i of 8'h5A during LOAD -> next frame sends 8'h5A.
- ss_n raised after 5 bits -> rx_full_o stays 0, miso_oe_o=0 within SYNC_STAGES+2 cycles, next full frame receives correctly.
- PRESET_n asserted mid-frame -> all outputs at reset values immediately. With SPI_SLAVE_LSBFE_EN defined and lsbfe_i=1, 8'h01 received appears as 8'h01 with LSB-first ordering on the wire.
